// File: rtl/mux41_rr_arbiter_if.sv
// Handshake bundle between the four requesters and the round-robin mux arbiter.
// The master side is the arbiter; the slave side is the requesting logic.
interface mux41_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       switch;

    modport master (
        input  req,
        output gnt,
        output sel,
        output valid,
        output switch
    );

    modport slave (
        output req,
        input  gnt,
        input  sel,
        input  valid,
        input  switch
    );
endinterface

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a
// bounded hold time per grant and fully registered outputs.
module mux41_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux41_rr_arbiter_if.master   bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    state_t             state_reg, state_next;
    logic [3:0]         gnt_reg, gnt_next;
    logic [1:0]         sel_reg, sel_next;
    logic               valid_reg, valid_next;
    logic               switch_reg, switch_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [1:0]         last_reg, last_next;

    logic [3:0]         search_req;
    logic [3:0]         others;
    logic [3:0]         rot_req;
    logic [1:0]         rot_idx [4];
    logic [1:0]         win_off;
    logic [1:0]         winner;
    logic               any_search;

    // The current holder is masked out so rotation never re-grants it while others wait.
    assign others     = bus.req & ~gnt_reg;
    assign search_req = (state_reg == IDLE) ? bus.req : others;
    assign any_search = |search_req;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_idx[gi] = last_reg + 2'(gi + 1);
            assign rot_req[gi] = search_req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) win_off = 2'(i);
        end
    end

    assign winner = last_reg + win_off + 2'd1;

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        sel_next      = sel_reg;
        valid_next    = valid_reg;
        switch_next   = 1'b0;
        hold_cnt_next = hold_cnt_reg;
        last_next     = last_reg;

        case (state_reg)
            IDLE: begin
                if (any_search) begin
                    state_next    = GRANT;
                    gnt_next      = 4'(1) << winner;
                    sel_next      = winner;
                    last_next     = winner;
                    valid_next    = 1'b1;
                    switch_next   = 1'b1;
                    hold_cnt_next = '0;
                end
            end
            GRANT: begin
                if ((!bus.req[sel_reg] || hold_cnt_reg == CNT_MAX) && any_search) begin
                    gnt_next      = 4'(1) << winner;
                    sel_next      = winner;
                    last_next     = winner;
                    switch_next   = 1'b1;
                    hold_cnt_next = '0;
                end else if (!bus.req[sel_reg]) begin
                    // sel keeps its value so the mux output stays stable while idle.
                    state_next    = IDLE;
                    gnt_next      = 4'b0000;
                    valid_next    = 1'b0;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg != CNT_MAX) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gnt_reg      <= 4'b0000;
            sel_reg      <= 2'd0;
            valid_reg    <= 1'b0;
            switch_reg   <= 1'b0;
            hold_cnt_reg <= '0;
            last_reg     <= 2'd3;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            sel_reg      <= sel_next;
            valid_reg    <= valid_next;
            switch_reg   <= switch_next;
            hold_cnt_reg <= hold_cnt_next;
            last_reg     <= last_next;
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.sel    = sel_reg;
    assign bus.valid  = valid_reg;
    assign bus.switch = switch_reg;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter: one DUT with HOLD_MAX=8, one with HOLD_MAX=1.
module tb_mux41_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux41_rr_arbiter_if bus_a ();
    mux41_rr_arbiter_if bus_b ();

    mux41_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    mux41_rr_arbiter #(.HOLD_MAX(1), .CNT_W(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.master)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] gnt, input logic [1:0] sel,
                           input logic valid, input logic sw);
        check({tag, ".gnt"},    bus_a.gnt,           gnt);
        check({tag, ".sel"},    {2'b00, bus_a.sel},  {2'b00, sel});
        check({tag, ".valid"},  {3'b000, bus_a.valid},  {3'b000, valid});
        check({tag, ".switch"}, {3'b000, bus_a.switch}, {3'b000, sw});
        $display("step %s: req=%b gnt=%b sel=%0d valid=%b switch=%b",
                 tag, bus_a.req, bus_a.gnt, bus_a.sel, bus_a.valid, bus_a.switch);
    endtask

    task automatic check_b(input string tag, input logic [3:0] gnt, input logic [1:0] sel,
                           input logic valid, input logic sw);
        check({tag, ".gnt"},    bus_b.gnt,           gnt);
        check({tag, ".sel"},    {2'b00, bus_b.sel},  {2'b00, sel});
        check({tag, ".valid"},  {3'b000, bus_b.valid},  {3'b000, valid});
        check({tag, ".switch"}, {3'b000, bus_b.switch}, {3'b000, sw});
        $display("step %s: req=%b gnt=%b sel=%0d valid=%b switch=%b",
                 tag, bus_b.req, bus_b.gnt, bus_b.sel, bus_b.valid, bus_b.switch);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.req = 4'b0000;
        bus_b.req = 4'b0000;
        step();
        check_a("rst_a", 4'b0000, 2'd0, 1'b0, 1'b0);
        check_b("rst_b", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int          idx;
        logic [3:0]  exp_gnt;

        bus_a.req = 4'b0000;
        bus_b.req = 4'b0000;

        // 1: single requester, one-cycle latency, held while asserted
        do_reset();
        step();
        check_a("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus_a.req = 4'b0001;
        step();
        check_a("t1_first", 4'b0001, 2'd0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_a("t1_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end

        // 2: all requesting, each holder keeps the mux for 8 cycles
        do_reset();
        bus_a.req = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            step();
            idx = (k / 8) % 4;
            exp_gnt = 4'(1) << idx;
            check_a("t2_walk", exp_gnt, 2'(idx), 1'b1, (k % 8) == 0);
        end

        // 3: lone holder keeps the grant indefinitely
        do_reset();
        bus_a.req = 4'b0100;
        step();
        check_a("t3_first", 4'b0100, 2'd2, 1'b1, 1'b1);
        for (int k = 0; k < 19; k++) begin
            step();
            check_a("t3_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end

        // 4: holder drops -> next in rotation, then wrap to source 0
        do_reset();
        bus_a.req = 4'b0100;
        step();
        check_a("t4_g2", 4'b0100, 2'd2, 1'b1, 1'b1);
        bus_a.req = 4'b1101;
        step();
        check_a("t4_keep2", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus_a.req = 4'b1001;
        step();
        check_a("t4_to3", 4'b1000, 2'd3, 1'b1, 1'b1);
        bus_a.req = 4'b0001;
        step();
        check_a("t4_wrap0", 4'b0001, 2'd0, 1'b1, 1'b1);
        bus_a.req = 4'b0000;
        step();
        check_a("t4_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 5: asynchronous reset mid-grant, search restarts at source 0
        do_reset();
        bus_a.req = 4'b0100;
        step();
        check_a("t5_g2", 4'b0100, 2'd2, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_a("t5_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus_a.req = 4'b1111;
        #1;
        rst_n = 1'b1;
        step();
        check_a("t5_restart", 4'b0001, 2'd0, 1'b1, 1'b1);

        // 6: HOLD_MAX=1 alternates every cycle; sel holds in idle
        do_reset();
        bus_b.req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k % 2 == 0) check_b("t6_alt1", 4'b0010, 2'd1, 1'b1, 1'b1);
            else            check_b("t6_alt3", 4'b1000, 2'd3, 1'b1, 1'b1);
        end
        bus_b.req = 4'b0000;
        step();
        check_b("t6_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        step();
        check_b("t6_idle2", 4'b0000, 2'd3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
